dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-port data memory between port 0 (core load/store unit) and port 1 (debug/program-loader).
- Drives the memory address, write-data and write-enable lines. The memory has a combinational read and a posedge write.
- Returns registered read data and a one-cycle response strobe to the granted port.
- Supports an optional bus lock so one port can perform back-to-back accesses without interleaving.

Parameters:
- DATA_W, 32, width of the data path and memory word.
- ADDR_W, 32, width of the address; the address is a word index passed unchanged to the memory.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held with addr0/wdata0/we0 stable until gnt0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 word address.
- wdata0  input  DATA_W  port 0 write data.
- lock0  input  1  port 0 requests to keep ownership after the current grant.
- gnt0  output  1  port 0 access performed this cycle (combinational).
- rvalid0  output  1  port 0 response strobe, one cycle after gnt0 (reads and writes).
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  output  DATA_W  registered read data, valid with rvalid0/rvalid1.
- mem_addr  output  ADDR_W  to memory address input.
- mem_wdata  output  DATA_W  to memory write-data input.
- mem_we  output  1  to memory write enable.
- mem_rdata  input  DATA_W  from memory combinational read-data output.

Behaviour:
- State:
  - rr_last: 1 bit, the last granted port.
  - owner: none/p0/p1, the lock holder.
  - rdata register.
  - rvalid0/rvalid1 registers.
- Reset (rst=1 at posedge):
  - rr_last=1, so port 0 wins the first tie.
  - owner=none.
  - rvalid0=rvalid1=0, rdata=0.
  - During any cycle with rst=1: gnt0=gnt1=0 and mem_we=0, so no write occurs.
- Grant, combinational from the current state:
  - owner=pX and reqX=1: grant pX only.
  - owner=pX and reqX=0: grant nobody. The other port waits until the lock is released.
  - owner=none, one request: grant that port.
  - owner=none, both requesting: grant the port != rr_last.
  - At most one of gnt0/gnt1 is high. A gnt never occurs without the matching req.
- Memory drive:
  - With gnt: mem_addr/mem_wdata = the winner's addr/wdata; mem_we = winner's we & gnt.
  - With no grant: mem_addr=addr0, mem_wdata=wdata0, mem_we=0.
- Posedge with gntX:
  - rr_last=X.
  - rvalidX=1 next cycle, and the other port's rvalid=0.
  - rdata=mem_rdata, sampled in the grant cycle. For a write, rdata holds the pre-write memory content (don't-care for requesters).
- Posedge without a grant: rvalid0=rvalid1=0 and rdata holds its value.
- Latency:
  - Grant is in the same cycle as the request when uncontested.
  - Response arrives 1 cycle after the grant.
  - Throughput is one access per cycle.
- Lock:
  - At posedge with gntX and lockX=1: owner=pX.
  - At posedge with gntX and lockX=0: owner=none.
  - With owner=pX, reqX=0 and lockX=0: owner=none.
- Fairness: with both requesting continuously and no locks, grants strictly alternate 0,1,0,1...
- Requester rule: when a port drops req without a grant, nothing happens and there is no state change.
- Reset mid-operation: a pending rvalid is cleared, the lock is released, and no memory write occurs in the reset cycle.

Test Plan:
1. Reset, then req0=1, we0=0, addr0=6 (mem[6]=30) -> gnt0=1 same cycle, mem_we=0; next cycle rvalid0=1, rdata=30, rvalid1=0.
2. req0 write addr0=30, wdata0=99 -> gnt0, mem_we=1; next cycle rvalid0=1; then a read of 30 via port 1 -> rvalid1 with rdata=99.
3. Both ports read continuously (addr0=40, addr1=50) for 4 cycles after reset -> gnt sequence 0,1,0,1; rdata sequence 50,60,50,60 with the matching rvalid.
4. Port 1 lock1=1 for 3 reads while req0 is held -> gnt1 on 3 consecutive cycles, gnt0=0; after lock1 drops on the final access, gnt0 the next cycle.
5. req0 write with rst=1 in the same cycle -> gnt0=0, mem_we=0, memory unchanged; rvalid0=0 after reset.
6. Owner=p1 (lock held), req1 drops with lock1=0 while req0=1 -> owner clears at that posedge; gnt0=1 the following cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              lock0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core (port 0)
// and the debug/loader port (port 1), with an optional per-port bus lock.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_P0,
    OWN_P1
  } owner_t;

  owner_t            owner_q;
  owner_t            owner_d;
  logic              rr_last_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      rr_last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      owner_q   <= owner_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        rr_last_q <= 1'b0;
      end else if (gnt1) begin
        rr_last_q <= 1'b1;
      end
      if (gnt0 || gnt1) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  // A lock holder blocks the other port even while it is idle between accesses.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    owner_d = owner_q;
    if (!rst) begin
      case (owner_q)
        OWN_P0: gnt0 = bus.req0;
        OWN_P1: gnt1 = bus.req1;
        default: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = rr_last_q;
            gnt1 = !rr_last_q;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
      endcase
    end

    if (gnt0) begin
      owner_d = bus.lock0 ? OWN_P0 : OWN_NONE;
    end else if (gnt1) begin
      owner_d = bus.lock1 ? OWN_P1 : OWN_NONE;
    end else if (owner_q == OWN_P0 && !bus.req0 && !bus.lock0) begin
      owner_d = OWN_NONE;
    end else if (owner_q == OWN_P1 && !bus.req1 && !bus.lock1) begin
      owner_d = OWN_NONE;
    end
  end

  always_comb begin
    addr_mux  = bus.addr0;
    wdata_mux = bus.wdata0;
    we_mux    = 1'b0;
    if (gnt1) begin
      addr_mux  = bus.addr1;
      wdata_mux = bus.wdata1;
      we_mux    = bus.we1;
    end else if (gnt0) begin
      we_mux    = bus.we0;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = we_mux;

endmodule
